// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-state issue/writeback controller wrapped around an 8-bit ALU.
// Holds a small register file, supplies registered operands and op code to the
// ALU, captures its combinational result and reports completion with done/err.
module alu_issue_ctrl #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] op_in,
  input  logic [1:0] rd_in,
  input  logic [1:0] ra_in,
  input  logic [1:0] rb_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_y,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       zero
);

  typedef enum logic [1:0] {IDLE, OPR, EXE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [1:0]             rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [7:0]             alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]             alu_ctrl_q, alu_ctrl_d;
  logic [NREG-1:0][7:0]   rf_q, rf_d;
  logic [7:0]             result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   legal;

  // Ops 000..100 are the only ones the ALU implements.
  assign legal = (op_q <= 3'd4);

  // Next-state and datapath: load port first so an EXE writeback to the same
  // address overrides it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    rf_d       = rf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (ld_en) rf_d[ld_addr] = ld_data;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = op_in;
          rd_d    = rd_in;
          ra_d    = ra_in;
          rb_d    = rb_in;
          state_d = OPR;
        end
      end
      OPR: begin
        // Pre-edge contents: a load landing on this edge is not seen.
        alu_a_d    = rf_q[ra_q];
        alu_b_d    = rf_q[rb_q];
        alu_ctrl_d = op_q;
        state_d    = EXE;
      end
      EXE: begin
        if (legal) begin
          rf_d[rd_q] = alu_y;
          result_d   = alu_y;
          zero_d     = (alu_y == 8'h00);
        end
        done_d  = 1'b1;
        err_d   = ~legal;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset beats the load port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      rf_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      rf_q       <= rf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign zero        = zero_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller that sits directly around the 8-bit ALU. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads two operands from an internal 4 x 8-bit register file. It drives the ALU's `a`, `b` and `alu_ctrl` inputs from registers, then captures the ALU's `y` output, writes it back and reports completion. It is the operand-supply and result-consumption stage for the ALU in the datapath.

## Interface
- `NREG` — default 4 — register-file depth, fixed at 4 (2-bit addresses); not to be changed.
- `clk` — in — 1 — the single clock; all state updates on the rising edge.
- `rst_n` — in — 1 — synchronous, active-low reset, sampled on `clk` rising edge.
- `instr_valid` — in — 1 — an instruction is presented.
- `instr_ready` — out — 1 — the block can accept an instruction.
- `op_in` — in — 3 — ALU op: 000 ADD, 001 SUB, 010 NOR, 011 SHL, 100 SHR; 101–111 illegal.
- `rd_in` — in — 2 — destination register.
- `ra_in` — in — 2 — operand A source register.
- `rb_in` — in — 2 — operand B source register.
- `alu_a` — out — 8 — registered operand A to the ALU.
- `alu_b` — out — 8 — registered operand B to the ALU.
- `alu_ctrl` — out — 3 — registered op code to the ALU.
- `alu_y` — in — 8 — combinational result from the ALU.
- `ld_en` — in — 1 — direct register-file load strobe.
- `ld_addr` — in — 2 — load address.
- `ld_data` — in — 8 — load data.
- `done` — out — 1 — one-cycle pulse marking instruction completion.
- `err` — out — 1 — one-cycle pulse, coincident with `done`, for an illegal op.
- `result` — out — 8 — last written-back value.
- `zero` — out — 1 — set when the last written-back value equals 0x00.

## Operation
- FSM states: IDLE, OPR, EXE.
- **IDLE**
  - `instr_ready` = 1.
  - On `instr_valid` & `instr_ready`: latch `op_in`/`rd_in`/`ra_in`/`rb_in` internally and go to OPR.
- **OPR**
  - `instr_ready` = 0.
  - At the edge: `alu_a` <= rf[ra], `alu_b` <= rf[rb], `alu_ctrl` <= op. Go to EXE.
  - Operands are the register-file contents before this edge. A load landing on the same edge is not seen.
- **EXE**
  - `instr_ready` = 0.
  - The ALU settles combinationally during this cycle.
  - At the edge, for a legal op: rf[rd] <= `alu_y`, `result` <= `alu_y`, `zero` <= (`alu_y` == 0), `done` <= 1.
  - At the edge, for an illegal op (101–111): no register-file write, `result`/`zero` unchanged, `done` <= 1, `err` <= 1.
  - Go to IDLE.
- `alu_a`, `alu_b` and `alu_ctrl` hold their values until the next OPR edge.
- `done` and `err` are high for exactly one cycle; that cycle is IDLE.
- **Load port**
  - `ld_en` writes rf[`ld_addr`] <= `ld_data` in any state.
  - If the EXE writeback targets the same address on the same edge, writeback wins and the load is dropped.
  - A load to a different address on that edge proceeds normally.
- `instr_valid` is ignored outside IDLE. The upstream holds it until it sees `instr_ready`.
- Arithmetic: all 8-bit and modulo 256; no carry or overflow outputs. Shifts are defined by the ALU; this block only forwards `alu_ctrl`.

## Timing
- Reset (`rst_n` low at an edge):
  - state <= IDLE.
  - All register-file entries <= 0x00.
  - `alu_a`, `alu_b`, `alu_ctrl`, `result` <= 0.
  - `zero` <= 1.
  - `done`, `err` <= 0.
  - `instr_ready` = 1 from the first cycle after reset.
- Reset mid-instruction aborts it: no writeback, no `done`.
- Reset takes priority over `ld_en`.
- Latency: accept edge t0, OPR edge t1, EXE edge t2. `done` is high during cycle t2..t3; `result` and the register file are valid from t2.
- Throughput: one instruction per 3 cycles. A new instruction may be accepted at t3 (while `done` is high), so back-to-back issue has no bubble beyond the 3-cycle period.
- A dependent instruction (reads rd of the previous one) accepted at t3 sees the new value; no forwarding is required.

## Test plan
- Load r1=0x05, r2=0x03; issue ADD rd=0 ra=1 rb=2 -> `alu_a`=0x05, `alu_b`=0x03, `alu_ctrl`=000 after OPR edge; `done` 3 cycles after accept; `result`=0x08, r0=0x08, `zero`=0.
- Same registers, SUB rd=3 ra=2 rb=1 -> `result`=0xFE. Then NOR with r1=0x0F, r2=0xF0 -> `result`=0x00, `zero`=1.
- SHL on r1=0x81 -> `result`=0x02. Immediately issue SHR on the same rd in the `done` cycle -> accepted that edge, reads 0x02, `result`=0x01.
- Illegal op 110 with rd=0 holding 0x08 -> `done`=1, `err`=1 for one cycle; r0 stays 0x08, `result`/`zero` unchanged.
- `ld_en` to rd with 0xAA on the EXE edge of ADD producing 0x08 -> rd=0x08. `instr_valid` held high during OPR/EXE -> only one instruction accepted.
- Drive `rst_n` low during EXE -> no `done`, all registers 0x00, `zero`=1, `instr_ready`=1 the next cycle.
